// File: rtl/draw_fade_if.sv
// draw_fade shared types and the VGA timing bundle.
// draw_fade_pkg holds the pixel width and the game_mode encoding shared with draw.
// vga_if carries the six timing fields: the "out" modport drives them and the "in" modport receives them.
package draw_fade_pkg;
  localparam int RGB_B  = 12;
  localparam int VCNT_W = 11;

  typedef enum logic [1:0] {
    MENU = 2'd0,
    GAME = 2'd1,
    WIN  = 2'd2,
    LOSE = 2'd3
  } game_mode;
endpackage

interface vga_if;
  logic [draw_fade_pkg::VCNT_W-1:0] vcount;
  logic                             vsync;
  logic                             vblnk;
  logic [draw_fade_pkg::VCNT_W-1:0] hcount;
  logic                             hsync;
  logic                             hblnk;

  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk);
  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk);
endinterface

// File: rtl/draw_fade.sv
// draw_fade: post-compositor fade stage between draw and the VGA pins.
// A mode change blanks the picture. It is then faded back in, one brightness step
// every FRAMES_PER_STEP frame starts. Timing passes through with one register stage.
// Optional macro DRAW_FADE_HOLD_EN: when defined, the picture is held black for
// HOLD_FRAMES frame starts before the fade-in begins. When undefined, the fade-in starts at once.
module draw_fade
  import draw_fade_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 2,
  parameter int HOLD_FRAMES     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  game_mode         mode,
  vga_if.in                vga_in,
  input  logic [RGB_B-1:0] rgb_in,
  vga_if.out               vga_out,
  output logic [RGB_B-1:0] rgb_out,
  output logic             fading
);

  localparam int CNT_MAX = (HOLD_FRAMES > FRAMES_PER_STEP) ? HOLD_FRAMES : FRAMES_PER_STEP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_FADE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [4:0]         level_q, level_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  game_mode           mode_q;
  logic [RGB_B-1:0]   rgb_q, rgb_d;
  logic               fading_q;

  logic               mode_chg_s;
  logic               frame_start_s;
  logic               blank_s;
  logic [CNT_W-1:0]   cnt_inc_s;

  // One 4-bit channel scaled by a 0..16 brightness: (c * level) >> 4, at most 15.
  function automatic logic [3:0] scale_ch(input logic [3:0] c, input logic [4:0] lv);
    scale_ch = 4'(({4'b0000, c} * {3'b000, lv}) >> 3'd4);
  endfunction

  assign mode_chg_s    = (mode != mode_q);
  assign frame_start_s = (vga_in.hcount == 11'd0) && (vga_in.vcount == 11'd0);
  assign blank_s       = vga_in.hblnk | vga_in.vblnk;
  assign cnt_inc_s     = cnt_q + CNT_W'(1);

  // Next fade state. A mode change overrides a frame start seen on the same cycle.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    if (mode_chg_s) begin
      level_d = 5'd0;
      cnt_d   = '0;
`ifdef DRAW_FADE_HOLD_EN
      state_d = S_HOLD;
`else
      state_d = S_FADE;
`endif
    end else if (frame_start_s) begin
      case (state_q)
        S_HOLD: begin
          if (cnt_inc_s == CNT_W'(HOLD_FRAMES)) begin
            cnt_d   = '0;
            state_d = S_FADE;
          end else begin
            cnt_d   = cnt_inc_s;
          end
        end
        S_FADE: begin
          if (cnt_inc_s == CNT_W'(FRAMES_PER_STEP)) begin
            cnt_d   = '0;
            level_d = level_q + 5'd1;
            if (level_q == 5'd15) begin
              state_d = S_IDLE;
            end else begin
              state_d = state_q;
            end
          end else begin
            cnt_d   = cnt_inc_s;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Pixel scaled by the level it takes on this edge, forced to black in blanking.
  always_comb begin
    rgb_d = '0;
    if (blank_s) begin
      rgb_d = '0;
    end else begin
      rgb_d = {scale_ch(rgb_in[11:8], level_d),
               scale_ch(rgb_in[7:4],  level_d),
               scale_ch(rgb_in[3:0],  level_d)};
    end
  end

  // State, counters and the one-cycle output register stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      level_q        <= 5'd16;
      cnt_q          <= '0;
      mode_q         <= MENU;
      rgb_q          <= '0;
      fading_q       <= 1'b0;
      vga_out.hcount <= 11'd0;
      vga_out.vcount <= 11'd0;
      vga_out.hsync  <= 1'b0;
      vga_out.vsync  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
    end else begin
      state_q        <= state_d;
      level_q        <= level_d;
      cnt_q          <= cnt_d;
      mode_q         <= mode;
      rgb_q          <= rgb_d;
      fading_q       <= (state_d != S_IDLE);
      vga_out.hcount <= vga_in.hcount;
      vga_out.vcount <= vga_in.vcount;
      vga_out.hsync  <= vga_in.hsync;
      vga_out.vsync  <= vga_in.vsync;
      vga_out.hblnk  <= vga_in.hblnk;
      vga_out.vblnk  <= vga_in.vblnk;
    end
  end

  assign rgb_out = rgb_q;
  assign fading  = fading_q;

endmodule

// File: tb/tb_draw_fade.sv
// Self-checking bench for draw_fade: table of pass-through/blanking vectors,
// hand-written fade sequences, then randomized traffic against a reference model
// that derives brightness from the number of frame starts since the last mode change.
module tb_draw_fade;
  import draw_fade_pkg::*;

  localparam int FPS  = 2;
  localparam int HOLD = 8;
`ifdef DRAW_FADE_HOLD_EN
  localparam int H = HOLD;
`else
  localparam int H = 0;
`endif
  localparam int BIG = 100000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  game_mode    mode = MENU;
  logic [11:0] rgb_in = 12'h000;
  logic [11:0] rgb_out;
  logic        fading;

  vga_if vin();
  vga_if vout();

  draw_fade #(.FRAMES_PER_STEP(FPS), .HOLD_FRAMES(HOLD)) dut (
    .clk    (clk),
    .rst    (rst),
    .mode   (mode),
    .vga_in (vin),
    .rgb_in (rgb_in),
    .vga_out(vout),
    .rgb_out(rgb_out),
    .fading (fading)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  int          m_n;
  game_mode    m_prev;
  logic [11:0] e_rgb;
  logic        e_fad;
  logic [25:0] e_vga;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Brightness from frame starts counted since the last mode change.
  function automatic int lvl_of(input int n);
    int v;
    if (n < H) return 0;
    v = (n - H) / FPS;
    return (v > 16) ? 16 : v;
  endfunction

  function automatic logic [11:0] scale_px(input logic [11:0] c, input int lv);
    int r, g, b;
    r = int'(c[11:8]) * lv / 16;
    g = int'(c[7:4])  * lv / 16;
    b = int'(c[3:0])  * lv / 16;
    return {r[3:0], g[3:0], b[3:0]};
  endfunction

  function automatic logic [25:0] vga_in_bus();
    return {vin.hcount, vin.vcount, vin.hsync, vin.vsync, vin.hblnk, vin.vblnk};
  endfunction

  task automatic model_reset();
    m_n    = BIG;
    m_prev = MENU;
    e_rgb  = 12'h000;
    e_fad  = 1'b0;
    e_vga  = 26'd0;
  endtask

  task automatic compare_all();
    check("rgb", rgb_out, e_rgb);
    check("fading", fading, e_fad);
    check("vga", {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk}, e_vga);
  endtask

  // One clock: predict from the inputs, clock, then compare.
  task automatic cyc();
    int  lv;
    bit  fs;
    fs = (vin.hcount == 11'd0) && (vin.vcount == 11'd0);
    if (mode != m_prev) m_n = 0;
    else if (fs && m_n < BIG) m_n++;
    m_prev = mode;
    lv     = lvl_of(m_n);
    e_rgb  = (vin.hblnk | vin.vblnk) ? 12'h000 : scale_px(rgb_in, lv);
    e_fad  = (lv != 16);
    e_vga  = vga_in_bus();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_px(input bit fs, input logic [11:0] rgb, input logic hb, input logic vb);
    vin.hcount = fs ? 11'd0 : 11'($urandom_range(1, 799));
    vin.vcount = fs ? 11'd0 : 11'($urandom_range(0, 524));
    vin.hsync  = 1'($urandom_range(0, 1));
    vin.vsync  = 1'($urandom_range(0, 1));
    vin.hblnk  = hb;
    vin.vblnk  = vb;
    rgb_in     = rgb;
  endtask

  // One short frame: a frame-start cycle followed by a visible pixel cycle.
  task automatic frame(input logic [11:0] rgb);
    set_px(1'b1, rgb, 1'b0, 1'b0);
    cyc();
    set_px(1'b0, rgb, 1'b0, 1'b0);
    cyc();
  endtask

  task automatic mid_reset();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("rst_async_rgb", rgb_out, 12'h000);
    check("rst_async_vga", {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk}, 26'd0);
    check("rst_async_fad", fading, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  typedef struct {
    logic [11:0] rgb;
    logic        hb;
    logic        vb;
    logic [10:0] h;
    logic [10:0] v;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{rgb: 12'hFFF, hb: 1'b1, vb: 1'b0, h: 11'd650, v: 11'd10,  exp: 12'h000};
    tbl[1] = '{rgb: 12'hFFF, hb: 1'b0, vb: 1'b1, h: 11'd5,   v: 11'd610, exp: 12'h000};
    tbl[2] = '{rgb: 12'hABC, hb: 1'b0, vb: 1'b0, h: 11'd100, v: 11'd200, exp: 12'hABC};
    tbl[3] = '{rgb: 12'h123, hb: 1'b0, vb: 1'b0, h: 11'd799, v: 11'd0,   exp: 12'h123};
    tbl[4] = '{rgb: 12'h000, hb: 1'b0, vb: 1'b0, h: 11'd1,   v: 11'd1,   exp: 12'h000};
    tbl[5] = '{rgb: 12'hFFF, hb: 1'b1, vb: 1'b1, h: 11'd700, v: 11'd600, exp: 12'h000};

    // reset state, then release with MENU and a visible pixel
    model_reset();
    set_px(1'b0, 12'hABC, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b1;
    cyc();
    check("rel_rgb", rgb_out, 12'hABC);
    check("rel_fading", fading, 1'b0);
    cyc();
    mid_reset();
    cyc();
    check("rel2_rgb", rgb_out, 12'hABC);

    // pass-through and blanking table at full brightness
    for (int i = 0; i < 6; i++) begin
      vin.hcount = tbl[i].h;
      vin.vcount = tbl[i].v;
      vin.hblnk  = tbl[i].hb;
      vin.vblnk  = tbl[i].vb;
      rgb_in     = tbl[i].rgb;
      cyc();
      check("tbl_rgb", rgb_out, tbl[i].exp);
      check("tbl_hcount", vout.hcount, tbl[i].h);
      check("tbl_vcount", vout.vcount, tbl[i].v);
      check("tbl_blnk", {vout.hblnk, vout.vblnk}, {tbl[i].hb, tbl[i].vb});
    end

    // full sequence MENU -> GAME with white
    mode = GAME;
    set_px(1'b0, 12'hFFF, 1'b0, 1'b0);
    cyc();
    check("seq1_chg_px", rgb_out, 12'h000);
    check("seq1_chg_fad", fading, 1'b1);
    for (int n = 1; n <= H + 32; n++) begin
      frame(12'hFFF);
      if (n == H)      check("seq1_hold_end", rgb_out, 12'h000);
      if (n == H + 1)  check("seq1_lvl0", rgb_out, 12'h000);
      if (n == H + 16) check("seq1_lvl8", rgb_out, 12'h777);
      if (n == H + 30) check("seq1_lvl15", rgb_out, 12'hEEE);
      if (n == H + 31) begin
        check("seq1_lvl15b", rgb_out, 12'hEEE);
        check("seq1_fad_hi", fading, 1'b1);
      end
      if (n == H + 32) begin
        check("seq1_done", rgb_out, 12'hFFF);
        check("seq1_fad_lo", fading, 1'b0);
      end
    end

    // GAME -> WIN with 808
    mode = WIN;
    set_px(1'b0, 12'h808, 1'b0, 1'b0);
    cyc();
    check("seq2_chg_px", rgb_out, 12'h000);
    for (int n = 1; n <= H + 32; n++) begin
      frame(12'h808);
      if (n == 1)      check("seq2_first", rgb_out, 12'h000);
      if (n == H + 31) check("seq2_lvl15", rgb_out, 12'h707);
      if (n == H + 32) begin
        check("seq2_done", rgb_out, 12'h808);
        check("seq2_fad_lo", fading, 1'b0);
      end
    end

    // restart mid-fade at level 9
    mode = MENU;
    set_px(1'b0, 12'hFFF, 1'b0, 1'b0);
    cyc();
    for (int n = 1; n <= H + 18; n++) frame(12'hFFF);
    check("rs_lvl9", rgb_out, 12'h888);
    mode = GAME;
    set_px(1'b0, 12'hFFF, 1'b0, 1'b0);
    cyc();
    check("rs_chg_px", rgb_out, 12'h000);
    check("rs_chg_fad", fading, 1'b1);
    for (int n = 1; n <= H + 32; n++) begin
      frame(12'hFFF);
      if (n == H + 1)  check("rs_lvl0", rgb_out, 12'h000);
      if (n == H + 31) check("rs_lvl15", rgb_out, 12'hEEE);
      if (n == H + 32) begin
        check("rs_done", rgb_out, 12'hFFF);
        check("rs_fad_lo", fading, 1'b0);
      end
    end

    // mode change coinciding with a frame start: that frame start is not counted
    mode = WIN;
    set_px(1'b1, 12'hFFF, 1'b0, 1'b0);
    cyc();
    check("sim_chg_px", rgb_out, 12'h000);
    for (int n = 1; n <= H + 32; n++) begin
      frame(12'hFFF);
      if (n == H + 3)  check("sim_lvl1", rgb_out, 12'h000);
      if (n == H + 4)  check("sim_lvl2", rgb_out, 12'h111);
      if (n == H + 32) check("sim_done", rgb_out, 12'hFFF);
    end

    // reset in the middle of a fade leaves no residual dimming
    mode = MENU;
    set_px(1'b0, 12'hFFF, 1'b0, 1'b0);
    cyc();
    for (int n = 1; n <= H + 10; n++) frame(12'hFFF);
    mid_reset();
    set_px(1'b0, 12'hFFF, 1'b0, 1'b0);
    cyc();
    check("rstmid_rgb", rgb_out, 12'hFFF);
    check("rstmid_fad", fading, 1'b0);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) mode = game_mode'($urandom_range(0, 3));
      set_px($urandom_range(0, 2) == 0, 12'($urandom),
             1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 9) == 0));
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/draw_fade.md
# draw_fade

Post-compositor fade stage between `draw` and the VGA output pins. It consumes `draw`'s registered timing bundle and RGB pixel. Whenever `mode` changes, it blanks the picture and then fades it back in over a programmable number of frames. Timing signals pass through with one register stage, so the block is transparent except for the brightness scaling.

## Interface
Parameters:
- `FRAMES_PER_STEP`, default 2: frame starts per brightness increment. Legal range is ≥1.
- `HOLD_FRAMES`, default 8: frame starts held at black before the fade-in begins. Legal range is ≥1.

Ports:
- `clk`: input, 1 bit. Pixel clock; the only clock in the block.
- `rst`: input, 1 bit. Reset, asynchronous and active-low.
- `mode`: input, `game_mode`. The same signal that drives `draw`.
- `vga_in`: `vga_if.in`. Timing bundle from `draw`.
- `rgb_in`: input, `RGB_B` bits. Pixel from `draw`, 4 bits each of R, G and B.
- `vga_out`: `vga_if.out`. Timing bundle delayed by 1 cycle.
- `rgb_out`: output, `RGB_B` bits. Scaled pixel.
- `fading`: output, 1 bit. High whenever the state is not IDLE.

## Operation
- **States:**
  - IDLE: level 16, pass-through.
  - HOLD: level 0.
  - FADE_IN: level 0..15, rising.
- **Registers:**
  - `level`: 5 bits, range 0..16.
  - `mode_q`: previous mode.
  - `frame_cnt`: wide enough for max(`HOLD_FRAMES`, `FRAMES_PER_STEP`).
- **Mode change detect:** `mode != mode_q`, with `mode_q <= mode` every cycle.
- **Frame start:** the cycle where `vga_in.hcount==0` and `vga_in.vcount==0`.
- **Transitions:**
  - On mode change, from any state: `level←0`, `frame_cnt←0`, go to HOLD.
  - HOLD: each frame start increments `frame_cnt`. On the frame start that makes the count equal `HOLD_FRAMES`, clear `frame_cnt` and go to FADE_IN with `level` still 0.
  - FADE_IN: each frame start increments `frame_cnt`. On the frame start that makes the count equal `FRAMES_PER_STEP`, clear `frame_cnt` and set `level←level+1`. When `level` reaches 16, go to IDLE.
  - IDLE: no change until the next mode change.
- **Simultaneous mode change and frame start:** the mode change wins. The frame start is not counted.
- **Scaling:** per channel, `out = (c * level) >> 4`.
  - Product is 4b×5b = 9 bits; the result is truncated to 4 bits.
  - Maximum result is 15, so there is no overflow.
  - At `level` 16 the output equals the input exactly. At `level` 0 the output is 0.
- **Blanking:** `rgb_out` is 0 whenever `vga_in.hblnk | vga_in.vblnk`, regardless of `level`.

## Timing
- **Latency:** `vga_out` and `rgb_out` are exactly 1 cycle after `vga_in` and `rgb_in`. All six `vga_if` fields are delayed together.
- **Level applied to a pixel:** each pixel is scaled by `level_nxt`, the value `level` takes on that same edge.
  - On a mode-change cycle, that pixel is already output as 0.
  - `draw` presents its first new-mode pixel one cycle after `mode` changes, so no new-mode pixel ever leaks at full brightness.
- **Reset values (while `rst`=0):**
  - State IDLE, `level` 16, `mode_q` = MENU, `frame_cnt` 0.
  - `rgb_out` 0, all `vga_out` fields 0, `fading` 0.
- **Mode after reset:** if `mode` ≠ MENU at the first cycle after reset release, a fade starts immediately.
- **Reset mid-fade:** returns to IDLE at `level` 16, with no residual dimming.
- **`fading`:** registered. It rises on the edge after the mode-change cycle and falls on the edge where `level` reaches 16.
- **Full sequence duration, with hold:** (`HOLD_FRAMES` + 16·`FRAMES_PER_STEP`) frame starts after the change.

## Configuration
- **Macro:** `DRAW_FADE_HOLD_EN`.
- **Defined:** HOLD exists as specified above.
- **Undefined:**
  - A mode change goes directly to FADE_IN with `level` 0 and `frame_cnt` 0.
  - `HOLD_FRAMES` is ignored.
  - Full duration is 16·`FRAMES_PER_STEP` frame starts.

## Test plan
- **Reset:** assert `rst`=0 mid-line → `rgb_out`=0 and `vga_out` all 0. Release with `mode`=MENU and `rgb_in`=12'hABC visible → `rgb_out`=12'hABC one cycle later, `fading`=0.
- **Full sequence with hold:** defaults, `DRAW_FADE_HOLD_EN` defined, `rgb_in`=12'hFFF, change MENU→GAME.
  - Output is 0 for 8 frame starts.
  - Level then increments every 2 frames: level 8 gives 12'h777, level 15 gives 12'hEEE.
  - At 40 frame starts the output is 12'hFFF and `fading` falls.
- **Blanking:** `hblnk`=1 with `rgb_in`=12'hFFF and `level` 16 → `rgb_out`=0.
- **Restart mid-fade:** second mode change at `level` 9 → the next pixel is 0, HOLD restarts, and the full 40-frame sequence repeats.
- **Simultaneous events:** mode change on the same cycle as a frame start → `frame_cnt` is 0 afterwards, and the hold still lasts exactly 8 further frame starts.
- **Macro undefined:** change GAME→WIN with 12'h808 → output is 0 on the first frame, then reaches 12'h808 after exactly 32 frame starts, with no HOLD.
